// File: rtl/qr_finder_pkg.sv
// Shared types and constants for the QR finder-pattern scan path.
// Holds the sequencer state enum, frame/encoding widths and the default scan timeout.
package qr_finder_pkg;

  localparam int FRAME_ADDR_W           = 20;
  localparam int ENC_W                  = 480;
  localparam int DEFAULT_TIMEOUT_CYCLES = 3 * 480 * 480 + 64;
  localparam int WD_W                   = 24;

  typedef enum logic [2:0] {
    IDLE,
    H_RESET,
    H_START,
    H_SCAN,
    V_RESET,
    V_START,
    V_SCAN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/scan_watchdog.sv
// Per-scan cycle watchdog: counts while enabled, flags when the limit is reached.
// Used by finder_scan_sequencer only when SCAN_TIMEOUT_EN is defined.
module scan_watchdog
  import qr_finder_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WD_W-1:0] count_q;
  logic [WD_W-1:0] count_d;

  // Holds at the limit so expired stays asserted until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == WD_W'(LIMIT - 1));

endmodule

// File: rtl/finder_scan_sequencer.sv
// Runs the horizontal then vertical finder scanners over one stored frame, sharing the
// frame-buffer read port. Optional scan watchdog enabled by defining SCAN_TIMEOUT_EN.
module finder_scan_sequencer
  import qr_finder_pkg::*;
#(
  parameter int WIDTH          = 480,
  parameter int HEIGHT         = 480,
  parameter int ADDR_W         = FRAME_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] h_addr_in,
  input  logic [ADDR_W-1:0] v_addr_in,
  input  logic [ENC_W-1:0]  h_enc_in,
  input  logic [ENC_W-1:0]  v_enc_in,
  input  logic              h_valid_in,
  input  logic              v_valid_in,
  output logic              scan_rst_out,
  output logic              h_start_out,
  output logic              v_start_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic              frame_lock_out,
  output logic              busy_out,
  output logic [ENC_W-1:0]  h_enc_out,
  output logic [ENC_W-1:0]  v_enc_out,
  output logic              result_valid_out,
  output logic              error_out
);

  if ((WIDTH * HEIGHT > (1 << ADDR_W)) || (TIMEOUT_CYCLES < 2) ||
      (TIMEOUT_CYCLES > (1 << WD_W))) begin : g_cfg_check
    $error("finder_scan_sequencer: frame does not fit ADDR_W or timeout out of range");
  end

  seq_state_t       state_q;
  logic             scan_rst_q;
  logic             h_start_q;
  logic             v_start_q;
  logic             result_valid_q;
  logic             error_q;
  logic [ENC_W-1:0] h_enc_q;
  logic [ENC_W-1:0] v_enc_q;
  logic             wd_expired;

`ifdef SCAN_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (state_q == H_START) || (state_q == V_START);
  assign wd_enable = (state_q == H_SCAN)  || (state_q == V_SCAN);

  scan_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk_in),
    .rst     (rst_in),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Pulses default low each cycle; a valid in the same cycle as expiry takes priority.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      scan_rst_q     <= 1'b0;
      h_start_q      <= 1'b0;
      v_start_q      <= 1'b0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      h_enc_q        <= '0;
      v_enc_q        <= '0;
    end else begin
      scan_rst_q     <= 1'b0;
      h_start_q      <= 1'b0;
      v_start_q      <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q    <= H_RESET;
            scan_rst_q <= 1'b1;
            error_q    <= 1'b0;
          end
        end
        H_RESET: begin
          state_q   <= H_START;
          h_start_q <= 1'b1;
        end
        H_START: state_q <= H_SCAN;
        H_SCAN: begin
          if (h_valid_in) begin
            h_enc_q    <= h_enc_in;
            state_q    <= V_RESET;
            scan_rst_q <= 1'b1;
          end else if (wd_expired) begin
            error_q    <= 1'b1;
            scan_rst_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        V_RESET: begin
          state_q   <= V_START;
          v_start_q <= 1'b1;
        end
        V_START: state_q <= V_SCAN;
        V_SCAN: begin
          if (v_valid_in) begin
            v_enc_q        <= v_enc_in;
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end else if (wd_expired) begin
            error_q    <= 1'b1;
            scan_rst_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bram_addr_out = '0;
    case (state_q)
      H_RESET, H_START, H_SCAN: bram_addr_out = h_addr_in;
      V_RESET, V_START, V_SCAN: bram_addr_out = v_addr_in;
      default:                  bram_addr_out = '0;
    endcase
  end

  assign busy_out         = (state_q != IDLE);
  assign frame_lock_out   = busy_out;
  assign scan_rst_out     = scan_rst_q;
  assign h_start_out      = h_start_q;
  assign v_start_out      = v_start_q;
  assign result_valid_out = result_valid_q;
  assign error_out        = error_q;
  assign h_enc_out        = h_enc_q;
  assign v_enc_out        = v_enc_q;

endmodule

// File: tb/tb_finder_scan_sequencer.sv
// Self-checking bench for finder_scan_sequencer: vector table, directed sequences and
// random traffic against a timeline model of the scan sequence.
module tb_finder_scan_sequencer;

  localparam int AW = 20;
  localparam int EW = 480;
  localparam int TO = 100;
`ifdef SCAN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hv = 1'b0;
  logic          vv = 1'b0;
  logic [AW-1:0] ha = '0;
  logic [AW-1:0] va = '0;
  logic [EW-1:0] he = '0;
  logic [EW-1:0] ve = '0;

  logic          scan_rst_o, h_start_o, v_start_o, frame_lock_o, busy_o, result_o, error_o;
  logic [AW-1:0] addr_o;
  logic [EW-1:0] h_enc_o, v_enc_o;

  always #5 clk = ~clk;

  finder_scan_sequencer #(
    .WIDTH(480), .HEIGHT(480), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .h_addr_in(ha), .v_addr_in(va), .h_enc_in(he), .v_enc_in(ve),
    .h_valid_in(hv), .v_valid_in(vv),
    .scan_rst_out(scan_rst_o), .h_start_out(h_start_o), .v_start_out(v_start_o),
    .bram_addr_out(addr_o), .frame_lock_out(frame_lock_o), .busy_out(busy_o),
    .h_enc_out(h_enc_o), .v_enc_out(v_enc_o),
    .result_valid_out(result_o), .error_out(error_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
    end
  endtask

  // Timeline model: times of the accepted start, accepted h/v valids, timeout, and idle return.
  int t0 = -1, tn = -1, tm = -1, tto = -1, tend = -1;
  logic [EW-1:0] m_h = '0, m_v = '0;
  bit m_err = 1'b0;

  function automatic bit active(input int k);
    return (t0 >= 0) && (k >= t0 + 1) && ((tend < 0) || (k < tend));
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int k);
    if (!active(k)) return '0;
    if (tm >= 0 && k >= tm + 1) return '0;
    if (tn < 0 || k <= tn) return ha;
    return va;
  endfunction

  task automatic model_update(input int c);
    if (rst) begin
      t0 = -1; tn = -1; tm = -1; tto = -1; tend = -1;
      m_h = '0; m_v = '0; m_err = 1'b0;
    end else if (!active(c)) begin
      if (start) begin
        t0 = c; tn = -1; tm = -1; tto = -1; tend = -1; m_err = 1'b0;
      end
    end else if (tn < 0 && c >= t0 + 3) begin
      if (hv) begin
        tn = c; m_h = he;
      end else if (TO_EN && c == t0 + 3 + TO - 1) begin
        tto = c; tend = c + 1; m_err = 1'b1;
      end
    end else if (tn >= 0 && tm < 0 && c >= tn + 3) begin
      if (vv) begin
        tm = c; tend = c + 2; m_v = ve;
      end else if (TO_EN && c == tn + 3 + TO - 1) begin
        tto = c; tend = c + 1; m_err = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int k;
    k = cyc_n;
    check("scan_rst", scan_rst_o, ((t0 >= 0 && k == t0 + 1) || (tn >= 0 && k == tn + 1) ||
                                   (tto >= 0 && k == tto + 1)));
    check("h_start", h_start_o, (t0 >= 0 && k == t0 + 2));
    check("v_start", v_start_o, (tn >= 0 && k == tn + 2));
    check("busy", busy_o, active(k));
    check("frame_lock", frame_lock_o, active(k));
    check("result_valid", result_o, (tm >= 0 && k == tm + 1));
    check("error", error_o, m_err);
    check("bram_addr", addr_o, exp_addr(k));
    check("h_enc", h_enc_o, m_h);
    check("v_enc", v_enc_o, m_v);
  endtask

  task automatic step(input bit r, input bit s, input bit h, input bit v);
    rst = r; start = s; hv = h; vv = v;
    model_update(cyc_n);
    @(posedge clk);
    #1;
    cyc_n++;
    compare_all();
  endtask

  task automatic rand_data();
    for (int i = 0; i < EW / 32; i++) begin
      he[i*32 +: 32] = $urandom;
      ve[i*32 +: 32] = $urandom;
    end
    ha = AW'($urandom);
    va = AW'($urandom);
  endtask

  typedef struct {
    bit s, h, v;
    bit e_srst, e_hs, e_vs, e_busy, e_res;
  } vec_t;

  vec_t vecs[9];
  int base;

  initial begin
    vecs[0] = '{1, 0, 0, 1, 0, 0, 1, 0};
    vecs[1] = '{0, 0, 0, 0, 1, 0, 1, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{0, 1, 0, 1, 0, 0, 1, 0};
    vecs[4] = '{0, 0, 1, 0, 0, 1, 1, 0};
    vecs[5] = '{1, 0, 0, 0, 0, 0, 1, 0};
    vecs[6] = '{0, 0, 1, 0, 0, 0, 1, 1};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{1, 0, 0, 1, 0, 0, 1, 0};

    // Reset, then idle for ten cycles with nonzero addresses on the scanner ports.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    ha = 20'd4321; va = 20'd8765;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check("idle_addr", addr_o, 20'd0);
    check("idle_h_enc", h_enc_o, '0);
    check("idle_busy", busy_o, 1'b0);

    // Vector table: handshake timing, ignored valids and ignored start while busy.
    for (int i = 0; i < 9; i++) begin
      rand_data();
      step(0, vecs[i].s, vecs[i].h, vecs[i].v);
      check("tbl_scan_rst", scan_rst_o, vecs[i].e_srst);
      check("tbl_h_start", h_start_o, vecs[i].e_hs);
      check("tbl_v_start", v_start_o, vecs[i].e_vs);
      check("tbl_busy", busy_o, vecs[i].e_busy);
      check("tbl_result", result_o, vecs[i].e_res);
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Full frame: h valid at cycle 20, v valid at 40, stray start/h_valid in V_SCAN.
    ha = 20'd12345; va = 20'd777;
    he = '0; he[5] = 1'b1;
    ve = '0; ve[100] = 1'b1;
    base = cyc_n;
    for (int i = 0; i < 46; i++) begin
      step(0, (i == 0) || (i == 30), (i == 20) || (i == 32), (i == 40));
      check("seq_result", result_o, (i + 1 == 41));
      check("seq_busy", busy_o, (i + 1 >= 1) && (i + 1 <= 41));
      if (i + 1 >= 3 && i + 1 <= 20) check("seq_addr_h", addr_o, 20'd12345);
      if (i + 1 >= 23 && i + 1 <= 40) check("seq_addr_v", addr_o, 20'd777);
    end
    check("seq_h_enc", h_enc_o, {{(EW-6){1'b0}}, 6'b100000});
    check("seq_v_enc", v_enc_o, {{(EW-101){1'b0}}, 1'b1, 100'd0});

    // Reset while in H_SCAN drops to idle and clears the latched encodings.
    for (int i = 0; i < 6; i++) step(0, (i == 0), 0, 0);
    step(1, 0, 0, 0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_h_enc", h_enc_o, '0);
    check("rst_v_enc", v_enc_o, '0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1);
      check("rst_no_result", result_o, 1'b0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rand_data();
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

`ifdef SCAN_TIMEOUT_EN
    // Horizontal scan never reports: watchdog aborts, then the next start clears error.
    step(1, 0, 0, 0);
    for (int i = 0; i < 110; i++) begin
      step(0, (i == 0), 0, 0);
      check("to_error", error_o, (i + 1 >= TO + 3));
      check("to_scan_rst", scan_rst_o, (i + 1 == 1) || (i + 1 == TO + 3));
      check("to_busy", busy_o, (i + 1 >= 1) && (i + 1 < TO + 3));
    end
    step(0, 1, 0, 0);
    check("to_error_clear", error_o, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
